// File: rtl/clarkpark_pkg.sv
// Shared clarkpark constants: angle/data widths, CORDIC arctangent
// table, gain compensation constant and the vectoring FSM encoding.
package clarkpark_pkg;

    localparam int IN_W       = 16;
    localparam int ANGLE_W    = 12;
    localparam int N_ITER_DEF = 14;
    localparam int ACC_W_DEF  = 16;
    localparam int XY_W_DEF   = 18;
    localparam int CORDIC_K   = 19898;
    localparam int K_W        = 15;

    typedef enum logic [1:0] {
        IDLE,
        PREP,
        ITER,
        DONE
    } vec_state_t;

    // atan(2^-i) in turns scaled by 2^16
    function automatic logic [15:0] atan_lut(input logic [3:0] i);
        case (i)
            4'd0:    return 16'd8192;
            4'd1:    return 16'd4836;
            4'd2:    return 16'd2555;
            4'd3:    return 16'd1297;
            4'd4:    return 16'd651;
            4'd5:    return 16'd326;
            4'd6:    return 16'd163;
            4'd7:    return 16'd81;
            4'd8:    return 16'd41;
            4'd9:    return 16'd20;
            4'd10:   return 16'd10;
            4'd11:   return 16'd5;
            4'd12:   return 16'd3;
            4'd13:   return 16'd1;
            4'd14:   return 16'd1;
            default: return 16'd0;
        endcase
    endfunction

endpackage

// File: rtl/cordic_vec_step.sv
// One CORDIC vectoring micro-rotation: drives y toward zero and
// accumulates the rotated angle.
module cordic_vec_step
    import clarkpark_pkg::*;
#(
    parameter int XY_W  = XY_W_DEF,
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic signed [XY_W-1:0]  x,
    input  logic signed [XY_W-1:0]  y,
    input  logic        [ACC_W-1:0] acc,
    input  logic        [3:0]       sh,
    output logic signed [XY_W-1:0]  x_n,
    output logic signed [XY_W-1:0]  y_n,
    output logic        [ACC_W-1:0] acc_n
);

    logic signed [XY_W-1:0]  xs;
    logic signed [XY_W-1:0]  ys;
    logic        [ACC_W-1:0] at;

    always_comb begin
        xs = x >>> sh;
        ys = y >>> sh;
        at = ACC_W'(atan_lut(sh));
        if (!y[XY_W-1]) begin
            x_n   = x + ys;
            y_n   = y - xs;
            acc_n = acc + at;
        end else begin
            x_n   = x - ys;
            y_n   = y + xs;
            acc_n = acc - at;
        end
    end

endmodule

// File: rtl/sincos_angle_decoder.sv
// Recovers phase angle and magnitude from a sin/cos pair using an
// iterative vectoring CORDIC with one shared micro-rotation stage.
module sincos_angle_decoder
    import clarkpark_pkg::*;
#(
    parameter int N_ITER = N_ITER_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int XY_W   = XY_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [IN_W-1:0]    is16_sin,
    input  logic [IN_W-1:0]    is16_cos,
    output logic               o_valid,
    output logic [ANGLE_W-1:0] or12_angle,
    output logic [15:0]        or16_mag
);

    localparam int PW = XY_W + K_W;
    localparam logic [3:0] LAST = 4'(N_ITER - 1);
    localparam logic [ACC_W-1:0] HALF = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [ACC_W-1:0] RND = ACC_W'(1 << (ACC_W - 13));
    localparam logic [K_W-1:0] K_U = K_W'(CORDIC_K);

    vec_state_t state;
    vec_state_t state_nxt;

    logic signed [XY_W-1:0]  sin_r;
    logic signed [XY_W-1:0]  cos_r;
    logic signed [XY_W-1:0]  x;
    logic signed [XY_W-1:0]  y;
    logic signed [XY_W-1:0]  x_n;
    logic signed [XY_W-1:0]  y_n;
    logic        [ACC_W-1:0] acc;
    logic        [ACC_W-1:0] acc_n;
    logic        [ACC_W-1:0] acc_rnd;
    logic        [3:0]       iter;
    logic                    zero_flag;
    logic        [PW-1:0]    prod;
    logic        [XY_W-1:0]  mag_full;
    logic        [15:0]      mag_sat;

    cordic_vec_step #(
        .XY_W  (XY_W),
        .ACC_W (ACC_W)
    ) u_step (
        .x     (x),
        .y     (y),
        .acc   (acc),
        .sh    (iter),
        .x_n   (x_n),
        .y_n   (y_n),
        .acc_n (acc_n)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (i_valid) state_nxt = PREP;
            PREP: state_nxt = ITER;
            ITER: if (iter == LAST) state_nxt = DONE;
            DONE: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        o_ready = (state == IDLE);
    end

    // Gain-compensated magnitude and rounded angle, used only in DONE
    always_comb begin
        prod     = {{K_W{1'b0}}, x} * {{XY_W{1'b0}}, K_U};
        mag_full = prod[PW-1:K_W];
        mag_sat  = (|mag_full[XY_W-1:16]) ? 16'hFFFF : mag_full[15:0];
        acc_rnd  = acc + RND;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sin_r      <= '0;
            cos_r      <= '0;
            x          <= '0;
            y          <= '0;
            acc        <= '0;
            iter       <= '0;
            zero_flag  <= 1'b0;
            o_valid    <= 1'b0;
            or12_angle <= '0;
            or16_mag   <= '0;
        end else begin
            o_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (i_valid) begin
                        sin_r <= {{(XY_W-IN_W){is16_sin[IN_W-1]}}, is16_sin};
                        cos_r <= {{(XY_W-IN_W){is16_cos[IN_W-1]}}, is16_cos};
                    end
                end
                PREP: begin
                    if (cos_r[XY_W-1]) begin
                        x   <= -cos_r;
                        y   <= -sin_r;
                        acc <= HALF;
                    end else begin
                        x   <= cos_r;
                        y   <= sin_r;
                        acc <= '0;
                    end
                    iter      <= '0;
                    zero_flag <= (sin_r == '0) && (cos_r == '0);
                end
                ITER: begin
                    x    <= x_n;
                    y    <= y_n;
                    acc  <= acc_n;
                    iter <= iter + 4'd1;
                end
                DONE: begin
                    o_valid <= 1'b1;
                    if (zero_flag) begin
                        or12_angle <= '0;
                        or16_mag   <= '0;
                    end else begin
                        or12_angle <= acc_rnd[ACC_W-1 -: ANGLE_W];
                        or16_mag   <= mag_sat;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sincos_angle_decoder.sv
// Self-checking bench for sincos_angle_decoder: vector table, DDS
// sweep, busy-input, zero-input and mid-operation reset sequences.
module tb_sincos_angle_decoder;

    localparam real PI = 3.14159265358979323846;
    localparam int LAT = 16;
    localparam int PERIOD = 17;

    typedef struct {
        int s;
        int c;
        int ang;
        int mag;
        int atol;
        int mtol;
    } vec_t;

    typedef struct {
        int ang;
        int mag;
        int atol;
        int mtol;
        int t_acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [15:0] is16_sin = '0;
    logic [15:0] is16_cos = '0;
    logic        o_valid;
    logic [11:0] or12_angle;
    logic [15:0] or16_mag;

    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb[$];
    exp_t mon_e;
    vec_t tab[8];

    sincos_angle_decoder dut (
        .clk        (clk),
        .rst        (rst),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .is16_sin   (is16_sin),
        .is16_cos   (is16_cos),
        .o_valid    (o_valid),
        .or12_angle (or12_angle),
        .or16_mag   (or16_mag)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int rnd(real v);
        if (v >= 0.0) return $rtoi(v + 0.5);
        return -$rtoi(-v + 0.5);
    endfunction

    function automatic int dds_sin(int k);
        return rnd(32767.0 * $sin(2.0 * PI * real'(k) / 4096.0));
    endfunction

    function automatic int dds_cos(int k);
        return rnd(32767.0 * $cos(2.0 * PI * real'(k) / 4096.0));
    endfunction

    function automatic int cdist(int a, int b);
        int d;
        d = ((a - b) % 4096 + 4096) % 4096;
        return (d < 4096 - d) ? d : 4096 - d;
    endfunction

    function automatic int iabs(int a);
        return (a < 0) ? -a : a;
    endfunction

    task automatic check(string name, bit ok, int act, int req);
        if (!ok) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Waits for idle, presents one sample and records its expectation
    task automatic send(int s, int c, int ang, int mag,
                        int atol, int mtol, bit do_push);
        int guard;
        exp_t e;
        guard = 0;
        @(negedge clk);
        while (!o_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("ready_timeout", o_ready, 0, 1);
        is16_sin = 16'(s);
        is16_cos = 16'(c);
        i_valid = 1'b1;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        n_vec++;
        if (do_push) begin
            e.ang = ang;
            e.mag = mag;
            e.atol = atol;
            e.mtol = mtol;
            e.t_acc = cyc;
            sb.push_back(e);
        end
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (sb.size() != 0 && guard < 60) begin
            @(negedge clk);
            guard++;
        end
        check("drain_timeout", sb.size() == 0, sb.size(), 0);
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (!rst && o_valid) begin
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_valid: got angle %0d mag %0d expected no strobe",
                         or12_angle, or16_mag);
            end else begin
                mon_e = sb.pop_front();
                check("angle", cdist(int'(or12_angle), mon_e.ang) <= mon_e.atol,
                      int'(or12_angle), mon_e.ang);
                check("mag", iabs(int'(or16_mag) - mon_e.mag) <= mon_e.mtol,
                      int'(or16_mag), mon_e.mag);
                check("latency", cyc - mon_e.t_acc == LAT,
                      cyc - mon_e.t_acc, LAT);
                check("ready_at_valid", o_ready, 0, 1);
            end
        end
    end

    initial begin
        int s;
        int c;
        int k;
        int t0;
        int acc_cnt;
        int last_t;
        int nv;
        bit rdy;

        tab[0] = '{s:     0, c:  32767, ang:    0, mag: 32767, atol: 0, mtol: 65};
        tab[1] = '{s: 32767, c:      0, ang: 1024, mag: 32767, atol: 0, mtol: 65};
        tab[2] = '{s:     0, c: -32768, ang: 2048, mag: 32768, atol: 0, mtol: 65};
        tab[3] = '{s:-32768, c:      0, ang: 3072, mag: 32768, atol: 0, mtol: 65};
        tab[4] = '{s: 23170, c: -23170, ang: 1536, mag: 32767, atol: 0, mtol: 65};
        tab[5] = '{s:-23170, c:  23170, ang: 3584, mag: 32767, atol: 0, mtol: 65};
        tab[6] = '{s:     0, c:      0, ang:    0, mag:     0, atol: 0, mtol: 0};
        tab[7] = '{s:  1000, c:   1000, ang:  512, mag:  1414, atol: 1, mtol: 65};

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_ready", o_ready, int'(o_ready), 1);
        check("reset_valid", !o_valid, int'(o_valid), 0);
        check("reset_angle", or12_angle == 12'd0, int'(or12_angle), 0);
        check("reset_mag", or16_mag == 16'd0, int'(or16_mag), 0);

        // first sample: busy window and exact strobe position
        send(0, 32767, 0, 32767, 0, 65, 1'b1);
        t0 = cyc;
        for (int i = 0; i < LAT; i++) begin
            @(negedge clk);
            if (cyc - t0 < LAT) begin
                check("busy_ready", !o_ready, int'(o_ready), 0);
                check("busy_valid", !o_valid, int'(o_valid), 0);
            end else begin
                check("strobe_valid", o_valid, int'(o_valid), 1);
            end
        end
        drain();

        for (int i = 0; i < 8; i++) begin
            send(tab[i].s, tab[i].c, tab[i].ang, tab[i].mag,
                 tab[i].atol, tab[i].mtol, 1'b1);
        end
        drain();

        // i_valid held high: only samples on accept edges are processed
        acc_cnt = 0;
        last_t = -1;
        for (int j = 0; j < 60; j++) begin
            @(negedge clk);
            k = (j * 97 + 300) % 4096;
            is16_sin = 16'(dds_sin(k));
            is16_cos = 16'(dds_cos(k));
            i_valid = 1'b1;
            rdy = o_ready;
            @(posedge clk);
            #1;
            if (rdy) begin
                sb.push_back('{ang: k, mag: 32767, atol: 1, mtol: 65, t_acc: cyc});
                acc_cnt++;
                n_vec++;
                if (last_t >= 0) check("accept_gap", cyc - last_t == PERIOD,
                                       cyc - last_t, PERIOD);
                last_t = cyc;
            end
        end
        @(negedge clk);
        i_valid = 1'b0;
        check("accept_count", acc_cnt == 4, acc_cnt, 4);
        drain();

        // reset during iteration 5 aborts the sample
        send(0, 32767, 0, 0, 0, 0, 1'b0);
        repeat (6) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_ready", o_ready, int'(o_ready), 1);
        check("abort_valid", !o_valid, int'(o_valid), 0);
        check("abort_angle", or12_angle == 12'd0, int'(or12_angle), 0);
        check("abort_mag", or16_mag == 16'd0, int'(or16_mag), 0);
        nv = 0;
        repeat (25) begin
            @(negedge clk);
            if (o_valid) nv++;
        end
        check("abort_no_strobe", nv == 0, nv, 0);
        send(32767, 0, 1024, 32767, 0, 65, 1'b1);
        drain();

        // full DDS table sweep
        for (int kk = 0; kk < 4096; kk++) begin
            s = dds_sin(kk);
            c = dds_cos(kk);
            send(s, c, kk, 32767, 1, 65, 1'b1);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
